// File: rtl/plot_pkg.sv
// Shared geometry, widths and FSM encoding for the pixel plot sink.
package plot_pkg;

    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned COLOUR_W   = 12;
    localparam int unsigned H_RES      = 160;
    localparam int unsigned V_RES      = 120;
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned FB_SIZE    = H_RES * V_RES;
    localparam int unsigned FIFO_DEPTH = 8;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO with a first-word-fall-through read port and full/empty flags.
module plot_fifo #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/pixel_plot_sink.sv
// Buffers x/y/colour plot strobes and drains them into the framebuffer write port;
// also sweeps the whole screen with a fill colour on request.
module pixel_plot_sink #(
    parameter int unsigned X_W        = plot_pkg::X_W,
    parameter int unsigned Y_W        = plot_pkg::Y_W,
    parameter int unsigned COLOUR_W   = plot_pkg::COLOUR_W,
    parameter int unsigned H_RES      = plot_pkg::H_RES,
    parameter int unsigned V_RES      = plot_pkg::V_RES,
    parameter int unsigned ADDR_W     = plot_pkg::ADDR_W,
    parameter int unsigned FIFO_DEPTH = plot_pkg::FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [X_W-1:0]      x,
    input  logic [Y_W-1:0]      y,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                plot,
    input  logic                clear_req,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                ready,
    output logic                busy,
    output logic                overflow,
    output logic                oob,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOUR_W-1:0] mem_data,
    output logic                mem_wren
);

    import plot_pkg::*;

    localparam int unsigned ENT_W = X_W + Y_W + COLOUR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    state_t              state_q, state_d;
    logic                clr_pend_q, clr_pend_d;
    logic [COLOUR_W-1:0] clr_colour_q, clr_colour_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [COLOUR_W-1:0] mem_data_q, mem_data_d;
    logic                mem_wren_q, mem_wren_d;
    logic                overflow_q, overflow_d;
    logic                oob_q, oob_d;

    logic [ENT_W-1:0]    rd_data;
    logic                fifo_full, fifo_empty, pop, drain, in_range;
    logic [X_W-1:0]      e_x;
    logic [Y_W-1:0]      e_y;
    logic [COLOUR_W-1:0] e_colour;
    logic [ADDR_W-1:0]   pix_addr;

    plot_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push    (plot && ready),
        .wr_data ({x, y, colour}),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ready    = !fifo_full;
    assign busy     = !fifo_empty || clr_pend_q || (state_q == CLEAR);
    assign overflow = overflow_q;
    assign oob      = oob_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_wren = mem_wren_q;

    always_comb begin
        e_x      = rd_data[ENT_W-1 -: X_W];
        e_y      = rd_data[COLOUR_W +: Y_W];
        e_colour = rd_data[COLOUR_W-1:0];
        in_range = ({1'b0, e_x} < (X_W+1)'(H_RES)) && ({1'b0, e_y} < (Y_W+1)'(V_RES));
        // 160 = 128 + 32, so the default geometry needs only shifts and adds
        if (H_RES == 160)
            pix_addr = (ADDR_W'(e_y) << 7) + (ADDR_W'(e_y) << 5) + ADDR_W'(e_x);
        else
            pix_addr = ADDR_W'(e_y) * ADDR_W'(H_RES) + ADDR_W'(e_x);
    end

    always_comb begin
        state_d      = state_q;
        clr_pend_d   = clr_pend_q;
        clr_colour_d = clr_colour_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_wren_d   = 1'b0;
        overflow_d   = overflow_q || (plot && !ready);
        oob_d        = oob_q;
        pop          = 1'b0;
        drain        = 1'b0;

        case (state_q)
            IDLE: drain = 1'b1;
            CLEAR: begin
                if (clr_pend_q) begin
                    mem_addr_d = '0;
                    mem_data_d = clr_colour_q;
                    mem_wren_d = 1'b1;
                    clr_pend_d = 1'b0;
                end else if (mem_addr_q != LAST_ADDR) begin
                    mem_addr_d = mem_addr_q + 1'b1;
                    mem_data_d = clr_colour_q;
                    mem_wren_d = 1'b1;
                end else begin
                    // sweep finished: fall straight into draining so queued plots follow without a gap
                    state_d = IDLE;
                    drain   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (drain) begin
            if (!fifo_empty) begin
                pop = 1'b1;
                if (in_range) begin
                    mem_addr_d = pix_addr;
                    mem_data_d = e_colour;
                    mem_wren_d = 1'b1;
                end else begin
                    oob_d = 1'b1;
                end
            end else if (clr_pend_q) begin
                state_d    = CLEAR;
                mem_addr_d = '0;
                mem_data_d = clr_colour_q;
                mem_wren_d = 1'b1;
                clr_pend_d = 1'b0;
            end
        end

        if (clear_req) begin
            clr_pend_d   = 1'b1;
            clr_colour_d = clear_colour;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            clr_pend_q   <= 1'b0;
            clr_colour_q <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_wren_q   <= 1'b0;
            overflow_q   <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_pend_q   <= clr_pend_d;
            clr_colour_q <= clr_colour_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_wren_q   <= mem_wren_d;
            overflow_q   <= overflow_d;
            oob_q        <= oob_d;
        end
    end

endmodule
